// File: rtl/io_bus_host_pkg.sv
// ---------------------------------------------------------------------------
// io_bus_host_pkg
// Shared definitions for the IO bus host:
//   - state_t   : host FSM states (IDLE, RUN, DRAIN, DONE)
//   - SEED_DEF  : default LFSR load value
//   - TAPS_DEF  : default feedback mask, x^16+x^14+x^13+x^11+1
//   - lfsr_step : one LFSR advance for the default 16-bit configuration
//   - misr_step : one MISR advance with oeb masking for the default config
// ---------------------------------------------------------------------------
package io_bus_host_pkg;

  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] TAPS_DEF = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] lfsr);
    return {lfsr[14:0], ^(lfsr & TAPS_DEF)};
  endfunction

  // Only pads the fabric drives (oeb=0) contribute to the signature.
  function automatic logic [15:0] misr_step(input logic [15:0] misr,
                                            input logic [15:0] pad_out,
                                            input logic [15:0] pad_oeb);
    return {misr[14:0], ^(misr & TAPS_DEF)} ^ (pad_out & ~pad_oeb);
  endfunction

endpackage

// File: rtl/io_bus_host_if.sv
// ---------------------------------------------------------------------------
// io_bus_host_if
// Bundles the run-control and fabric pad signals of the IO bus host.
//   master modport : the host (io_bus_host) side
//     in : start, cycles, fab_io_out, fab_io_oeb
//     out: fab_io_in, busy, done, signature, oeb_err, dbg_state
//   slave modport  : the controller / fabric side (directions reversed)
// Handshake: start is a single-cycle request accepted only when the host is
// IDLE; there is no ready/queueing, a start seen in any other state is lost.
// done is a one-cycle completion pulse; signature is valid from the cycle
// after done until the next accepted start.
// ---------------------------------------------------------------------------
interface io_bus_host_if
  import io_bus_host_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) ();

  logic             start;
  logic [CNT_W-1:0] cycles;
  logic [WIDTH-1:0] fab_io_out;
  logic [WIDTH-1:0] fab_io_oeb;
  logic [WIDTH-1:0] fab_io_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic             oeb_err;
  state_t           dbg_state;

  modport master (
    input  start, cycles, fab_io_out, fab_io_oeb,
    output fab_io_in, busy, done, signature, oeb_err, dbg_state
  );

  modport slave (
    output start, cycles, fab_io_out, fab_io_oeb,
    input  fab_io_in, busy, done, signature, oeb_err, dbg_state
  );

endinterface

// File: rtl/io_bus_host_misr.sv
// ---------------------------------------------------------------------------
// io_bus_host_misr
// Multiple-input signature register. Shifts left with parity feedback taken
// through TAPS and folds the (already masked) data word in every enabled
// cycle.
//   clk, rst : clock, synchronous active-high reset (state -> 0)
//   clear    : synchronous clear, wins over enable
//   enable   : advance one step this cycle
//   data     : word folded into the signature
//   state    : current signature
// ---------------------------------------------------------------------------
module io_bus_host_misr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= '0;
    end else if (enable) begin
      state <= {state[WIDTH-2:0], ^(state & TAPS)} ^ data;
    end
  end

endmodule

// File: rtl/io_bus_host.sv
// ---------------------------------------------------------------------------
// io_bus_host
// Host-side stimulus/capture engine for the fabric IO pads. During a run it
// drives LFSR data onto every pad the fabric treats as an input (oeb=1) and
// compresses every pad the fabric drives (oeb=0) into a MISR signature. After
// the stimulus cycles it keeps capturing for FABRIC_LAT drain cycles so that
// pipelined fabric outputs still reach the signature.
//   clk, rst : clock, synchronous active-high reset (aborts a run silently)
//   bus      : io_bus_host_if.master (start/cycles in, pads, busy/done,
//              signature, oeb_err, dbg_state)
// Optional feature macro IO_BUS_HOST_OEB_CHECK_EN: latches oeb on the first
// RUN cycle and raises sticky oeb_err if oeb later differs during RUN/DRAIN.
// Without it oeb_err is tied low.
// ---------------------------------------------------------------------------
module io_bus_host
  import io_bus_host_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               CNT_W      = 16,
  parameter logic [WIDTH-1:0] SEED       = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
  parameter int               FABRIC_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  io_bus_host_if.master bus
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(FABRIC_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] lfsr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] fab_io_in_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] signature_q;
  logic [WIDTH-1:0] misr_q;
  logic [WIDTH-1:0] capture;
  logic             accept;
  logic             misr_en;

  assign accept  = (state == IDLE) && bus.start;
  assign misr_en = (state == RUN) || (state == DRAIN);
  assign capture = bus.fab_io_out & ~bus.fab_io_oeb;

  // cnt counts stimulus cycles in RUN and is reloaded with FABRIC_LAT for
  // DRAIN; in both states cnt==1 marks the last cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = (bus.cycles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_ONE) begin
          next_state = (FABRIC_LAT > 0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (cnt == CNT_ONE) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      cnt         <= '0;
      fab_io_in_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      signature_q <= '0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state == RUN) || (next_state == DRAIN);
      done_q <= (next_state == DONE);
      // Pads the fabric drives always see 0 from the host.
      fab_io_in_q <= (state == RUN) ? (lfsr & bus.fab_io_oeb) : '0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            lfsr <= SEED;
            cnt  <= bus.cycles;
          end
        end
        RUN: begin
          lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
          cnt  <= (cnt == CNT_ONE) ? DRAIN_LOAD : cnt - CNT_ONE;
        end
        DRAIN: begin
          cnt <= cnt - CNT_ONE;
        end
        DONE: begin
          signature_q <= misr_q;
        end
        default: ;
      endcase
    end
  end

  // Cleared on every accepted start so a zero-cycle run yields signature 0.
  io_bus_host_misr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (misr_en),
    .data   (capture),
    .state  (misr_q)
  );

`ifdef IO_BUS_HOST_OEB_CHECK_EN
  logic [WIDTH-1:0] oeb_ref;
  logic             oeb_ref_vld;
  logic             oeb_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      oeb_ref     <= '0;
      oeb_ref_vld <= 1'b0;
      oeb_err_q   <= 1'b0;
    end else if (accept) begin
      oeb_ref_vld <= 1'b0;
      oeb_err_q   <= 1'b0;
    end else if ((state == RUN) && !oeb_ref_vld) begin
      oeb_ref     <= bus.fab_io_oeb;
      oeb_ref_vld <= 1'b1;
    end else if (misr_en && (bus.fab_io_oeb != oeb_ref)) begin
      oeb_err_q <= 1'b1;
    end
  end

  assign bus.oeb_err = oeb_err_q;
`else
  assign bus.oeb_err = 1'b0;
`endif

  assign bus.fab_io_in = fab_io_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = signature_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_io_bus_host.sv
// ---------------------------------------------------------------------------
// tb_io_bus_host
// Directed bench for io_bus_host (WIDTH=16, CNT_W=16, FABRIC_LAT=2).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_io_bus_host;
  import io_bus_host_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  io_bus_host_if #(.WIDTH(16), .CNT_W(16)) bus ();

  io_bus_host #(
    .WIDTH      (16),
    .CNT_W      (16),
    .SEED       (16'hACE1),
    .TAPS       (16'hB400),
    .FABRIC_LAT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  // observations collected by watch_run
  logic [15:0] seen_in [0:31];
  int          done_at;
  int          done_n;
  int          busy_n;
  logic [15:0] sig_after;
  logic [15:0] exp_q [$];

  // driver tasks
  task automatic do_start(input logic [15:0] cyc);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cycles = cyc;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cycles = 16'h0000;
  endtask

  // Called at the first falling edge after the accepting edge (index 1).
  task automatic watch_run(input int max_i);
    done_at   = 0;
    done_n    = 0;
    busy_n    = 0;
    sig_after = 16'hxxxx;
    for (int i = 1; i <= max_i; i++) begin
      if (i > 1) @(negedge clk);
      if (i < 32) seen_in[i] = bus.fab_io_in;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at == 0) done_at = i;
      end
      if (done_at != 0 && i == done_at + 1) sig_after = bus.signature;
    end
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    tests_run++;
    if (bus.fab_io_in !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_fab_io_in: got %h want 0000", bus.fab_io_in);
    end
    tests_run++;
    if (bus.signature !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_signature: got %h want 0000", bus.signature);
    end
    tests_run++;
    if (bus.oeb_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_oeb_err: got %b want 0", bus.oeb_err);
    end
    tests_run++;
    if (bus.dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d want IDLE", bus.dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_masked_outputs;
    bus.fab_io_oeb = 16'hFFFF;
    bus.fab_io_out = 16'hFFFF;
    do_start(16'd1);
    watch_run(8);
    tests_run++;
    if (done_at !== 4) begin
      tests_failed++; $display("FAIL masked_done_at: got %0d want 4", done_at);
    end
    tests_run++;
    if (busy_n !== 3 || done_n !== 1) begin
      tests_failed++; $display("FAIL masked_busy_done: busy %0d done %0d want 3 1", busy_n, done_n);
    end
    tests_run++;
    if (seen_in[2] !== 16'hACE1 || seen_in[3] !== 16'h0000) begin
      tests_failed++; $display("FAIL masked_fab_io_in: got %h %h want ace1 0000", seen_in[2], seen_in[3]);
    end
    tests_run++;
    if (sig_after !== 16'h0000) begin
      tests_failed++; $display("FAIL masked_signature: got %h want 0000", sig_after);
    end
  endtask

  task automatic test_reset_mid_run;
    int dn;
    bus.fab_io_oeb = 16'hFFFF;
    bus.fab_io_out = 16'h0000;
    do_start(16'd5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;                       // during the 3rd RUN cycle
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (bus.dbg_state !== IDLE || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_idle: state %0d busy %b want IDLE 0", bus.dbg_state, bus.busy);
    end
    tests_run++;
    if (bus.fab_io_in !== 16'h0000 || bus.signature !== 16'h0000) begin
      tests_failed++; $display("FAIL midrst_outputs: in %h sig %h want 0000 0000", bus.fab_io_in, bus.signature);
    end
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    tests_run++;
    if (dn !== 0) begin
      tests_failed++; $display("FAIL midrst_no_done: got %0d done pulses want 0", dn);
    end
  endtask

  task automatic test_lfsr_seq;
    bus.fab_io_out = 16'h0000;
    bus.fab_io_oeb = 16'hFFFF;
    do_start(16'd2);
    watch_run(8);
    tests_run++;
    if (seen_in[2] !== 16'hACE1 || seen_in[3] !== 16'h59C3 || seen_in[4] !== 16'h0000) begin
      tests_failed++; $display("FAIL lfsr_seq_ffff: got %h %h %h want ace1 59c3 0000", seen_in[2], seen_in[3], seen_in[4]);
    end
    tests_run++;
    if (done_at !== 5) begin
      tests_failed++; $display("FAIL lfsr_done_at: got %0d want 5", done_at);
    end
    bus.fab_io_oeb = 16'h00FF;
    do_start(16'd2);
    watch_run(8);
    tests_run++;
    if (seen_in[2] !== 16'h00E1 || seen_in[3] !== 16'h00C3) begin
      tests_failed++; $display("FAIL lfsr_seq_00ff: got %h %h want 00e1 00c3", seen_in[2], seen_in[3]);
    end
  endtask

  task automatic test_misr;
    bus.fab_io_oeb = 16'h0000;
    bus.fab_io_out = 16'h0001;
    do_start(16'd1);
    watch_run(8);
    tests_run++;
    if (seen_in[2] !== 16'h0000) begin
      tests_failed++; $display("FAIL misr_fab_io_in: got %h want 0000", seen_in[2]);
    end
    tests_run++;
    if (done_at !== 4 || sig_after !== 16'h0007) begin
      tests_failed++; $display("FAIL misr_signature: done_at %0d sig %h want 4 0007", done_at, sig_after);
    end
  endtask

  task automatic test_zero_cycles;
    bus.fab_io_oeb = 16'h0000;
    bus.fab_io_out = 16'h0001;
    do_start(16'd0);
    watch_run(6);
    tests_run++;
    if (done_at !== 1 || done_n !== 1) begin
      tests_failed++; $display("FAIL zero_done: at %0d count %0d want 1 1", done_at, done_n);
    end
    tests_run++;
    if (busy_n !== 0) begin
      tests_failed++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_n);
    end
    tests_run++;
    if (sig_after !== 16'h0000) begin
      tests_failed++; $display("FAIL zero_signature: got %h want 0000", sig_after);
    end
  endtask

  // Starts during RUN and during DONE must both be dropped.
  task automatic test_back_to_back;
    int d_at, d_n, b_n, b_late;
    bus.fab_io_oeb = 16'hFFFF;
    bus.fab_io_out = 16'h0000;
    do_start(16'd3);
    d_at = 0; d_n = 0; b_n = 0; b_late = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) begin
        b_n++;
        if (d_at != 0) b_late++;
      end
      if (bus.done) begin
        d_n++;
        if (d_at == 0) d_at = i;
        bus.start  = 1'b1;
        bus.cycles = 16'd2;
      end
      if (i == 2) begin
        bus.start  = 1'b1;
        bus.cycles = 16'd1;
      end
    end
    bus.start = 1'b0;
    tests_run++;
    if (d_at !== 6 || d_n !== 1) begin
      tests_failed++; $display("FAIL b2b_done: at %0d count %0d want 6 1", d_at, d_n);
    end
    tests_run++;
    if (b_n !== 5 || b_late !== 0) begin
      tests_failed++; $display("FAIL b2b_busy: busy %0d after_done %0d want 5 0", b_n, b_late);
    end
  endtask

  task automatic test_scoreboard;
    logic [15:0] l, m, exp_v;
    bus.fab_io_oeb = 16'h00FF;
    bus.fab_io_out = 16'h1234;
    exp_q.delete();
    l = SEED_DEF;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(l & 16'h00FF);
      l = lfsr_step(l);
    end
    m = 16'h0000;
    for (int k = 0; k < 6; k++) m = misr_step(m, 16'h1234, 16'h00FF);
    do_start(16'd4);
    watch_run(10);
    for (int k = 2; k <= 5; k++) begin
      exp_v = exp_q.pop_front();
      tests_run++;
      if (seen_in[k] !== exp_v) begin
        tests_failed++; $display("FAIL sb_fab_io_in[%0d]: got %h want %h", k, seen_in[k], exp_v);
      end
    end
    tests_run++;
    if (done_at !== 7 || sig_after !== m) begin
      tests_failed++; $display("FAIL sb_signature: done_at %0d sig %h want 7 %h", done_at, sig_after, m);
    end
  endtask

  task automatic test_oeb_check;
    logic err_at_done, d_seen;
    logic exp_err;
`ifdef IO_BUS_HOST_OEB_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    bus.fab_io_oeb = 16'hFFFF;
    bus.fab_io_out = 16'h0000;
    do_start(16'd4);
    err_at_done = 1'b0;
    d_seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.done) begin
        d_seen = 1'b1;
        err_at_done = bus.oeb_err;
      end
      if (i == 3) bus.fab_io_oeb = 16'hFFFE;  // 3rd RUN cycle
    end
    tests_run++;
    if (d_seen !== 1'b1 || err_at_done !== exp_err) begin
      tests_failed++; $display("FAIL oeb_err_set: done %b err %b want 1 %b", d_seen, err_at_done, exp_err);
    end
    tests_run++;
    if (bus.oeb_err !== exp_err) begin
      tests_failed++; $display("FAIL oeb_err_sticky: got %b want %b", bus.oeb_err, exp_err);
    end
    bus.fab_io_oeb = 16'hFFFF;
    do_start(16'd1);
    tests_run++;
    if (bus.oeb_err !== 1'b0) begin
      tests_failed++; $display("FAIL oeb_err_clear: got %b want 0", bus.oeb_err);
    end
    watch_run(6);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.cycles     = 16'h0000;
    bus.fab_io_out = 16'h0000;
    bus.fab_io_oeb = 16'hFFFF;
    test_reset();
    test_masked_outputs();
    test_reset_mid_run();
    test_lfsr_seq();
    test_misr();
    test_zero_cycles();
    test_back_to_back();
    test_scoreboard();
    test_oeb_check();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
